// File: rtl/bp_me_ct_credit_returner.sv
// Receive endpoint of the credit-based channel tunnel: buffers pushed flits,
// hands them to a valid/yumi consumer and returns credits in decimated batches.
module bp_me_ct_credit_returner #(
  parameter int flit_width_p           = 30,
  parameter int remote_credits_p       = 32,
  parameter int lg_credit_decimation_p = 3
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  link_v_i,
  input  logic [flit_width_p-1:0]               link_data_i,
  output logic                                  v_o,
  output logic [flit_width_p-1:0]               data_o,
  input  logic                                  yumi_i,
  output logic                                  credit_v_o,
  output logic [$clog2(remote_credits_p):0]     count_o,
  output logic                                  overflow_o
);

  localparam int ptr_w_lp  = (remote_credits_p > 1) ? $clog2(remote_credits_p) : 1;
  localparam int cnt_w_lp  = $clog2(remote_credits_p) + 1;
  localparam int cred_w_lp = lg_credit_decimation_p + 1;
  localparam logic [cnt_w_lp-1:0]  depth_lp = cnt_w_lp'(remote_credits_p);
  localparam logic [cred_w_lp-1:0] batch_lp = cred_w_lp'(1) << lg_credit_decimation_p;

  logic [flit_width_p-1:0] mem_r [remote_credits_p];
  logic [ptr_w_lp-1:0]     wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0]     count_r;
  logic [cred_w_lp-1:0]    pend_r, pend_inc;
  logic                    credit_r, ovf_r;
  logic                    full, enq, deq, drop, batch_done;

  // Full is judged on registered occupancy, so a same-cycle dequeue never
  // makes room for an incoming flit.
  assign full       = (count_r == depth_lp);
  assign v_o        = (count_r != '0);
  assign enq        = link_v_i & ~full;
  assign drop       = link_v_i & full;
  assign deq        = yumi_i & v_o;
  assign pend_inc   = pend_r + cred_w_lp'(1);
  assign batch_done = deq & (pend_inc == batch_lp);

  assign data_o     = mem_r[rd_ptr_r];
  assign count_o    = count_r;
  assign credit_v_o = credit_r;
  assign overflow_o = ovf_r;

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= link_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      pend_r   <= '0;
      credit_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
      if (deq) rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
      if (deq) pend_r <= batch_done ? '0 : pend_inc;
      credit_r <= batch_done;
      if (drop) ovf_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_me_ct_credit_returner.sv
// Directed bench for bp_me_ct_credit_returner: a scoreboard queue holds the
// expected flit order, a small occupancy/credit model predicts the outputs.
module tb_bp_me_ct_credit_returner;

  localparam int W = 30;
  localparam int D = 32;
  localparam int B = 8;

  logic         clk = 1'b0;
  logic         reset_i, link_v_i, yumi_i;
  logic [W-1:0] link_data_i, data_o;
  logic         v_o, credit_v_o, overflow_o;
  logic [5:0]   count_o;

  bp_me_ct_credit_returner #(
    .flit_width_p(W), .remote_credits_p(D), .lg_credit_decimation_p(3)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .link_v_i(link_v_i), .link_data_i(link_data_i),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .credit_v_o(credit_v_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int m_count, m_pend, m_credits;
  bit m_credit, m_ovf;
  int total = 0, passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic cyc(input bit lv, input logic [W-1:0] d, input bit y);
    bit do_deq;
    link_v_i = lv; link_data_i = d; yumi_i = y;
    do_deq = y && (m_count > 0);
    m_credit = 1'b0;
    if (do_deq) begin
      chk("head_data", data_o, exp_q.pop_front());
      m_pend++;
      if (m_pend == B) begin m_pend = 0; m_credit = 1'b1; end
    end
    if (lv) begin
      if (m_count < D) exp_q.push_back(d);
      else m_ovf = 1'b1;
    end
    m_count = exp_q.size();
    @(posedge clk); #1;
    if (credit_v_o) m_credits++;
    chk("count", count_o, m_count);
    chk("v", v_o, m_count > 0);
    chk("credit", credit_v_o, m_credit);
    chk("overflow", overflow_o, m_ovf);
    link_v_i = 0; yumi_i = 0;
  endtask

  task automatic do_reset();
    reset_i = 1; link_v_i = 0; yumi_i = 0;
    @(posedge clk); #1;
    reset_i = 0;
    exp_q.delete(); m_count = 0; m_pend = 0; m_credit = 0; m_ovf = 0;
    chk("rst_v", v_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_credit", credit_v_o, 0);
    chk("rst_ovf", overflow_o, 0);
  endtask

  initial begin
    reset_i = 1; link_v_i = 0; yumi_i = 0; link_data_i = '0;
    @(posedge clk); #1;
    do_reset();

    // single flit, one-cycle latency
    for (int i = 0; i < 3; i++) cyc(0, '0, 0);
    cyc(1, W'(32'h1234567), 0);
    chk("single_data", data_o, W'(32'h1234567));
    chk("single_count", count_o, 1);

    // fill 32, drain 32, four credit batches
    do_reset();
    m_credits = 0;
    for (int i = 0; i < D; i++) cyc(1, W'(i), 0);
    chk("full_count", count_o, D);
    for (int i = 0; i < D; i++) cyc(0, '0, 1);
    chk("batches", m_credits, 4);
    chk("drained", count_o, 0);

    // overflow with same-cycle dequeue
    for (int i = 0; i < D; i++) cyc(1, W'(100 + i), 0);
    cyc(1, W'(30'h0BAD), 1);
    chk("ovf_set", overflow_o, 1);
    chk("ovf_count", count_o, D - 1);
    chk("ovf_head", data_o, W'(101));
    cyc(0, '0, 0);
    chk("ovf_sticky", overflow_o, 1);

    // streaming at occupancy 1 across pointer wrap
    do_reset();
    m_credits = 0;
    cyc(1, W'(500), 0);
    for (int i = 0; i < 100; i++) cyc(1, W'(501 + i), 1);
    chk("stream_count", count_o, 1);
    chk("stream_batches", m_credits, 100 / B);

    // yumi while empty is ignored
    cyc(0, '0, 1);
    for (int i = 0; i < 10; i++) cyc(0, '0, 1);
    chk("empty_count", count_o, 0);

    // held credits discarded by reset
    do_reset();
    for (int i = 0; i < 13; i++) cyc(1, W'(700 + i), 0);
    for (int i = 0; i < 5; i++) cyc(0, '0, 1);
    do_reset();
    m_credits = 0;
    for (int i = 0; i < B; i++) cyc(1, W'(800 + i), 0);
    for (int i = 0; i < B; i++) cyc(0, '0, 1);
    chk("post_rst_batches", m_credits, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
